// File: rtl/immediate_encode.sv
// immediate_encode: packs a 32-bit immediate into the U/J/I/B/S fields of an instruction template,
// flags range/alignment/select errors and counts errored words, behind a 2-stage valid/ready pipeline.
module immediate_encode #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_template,
    input  logic [31:0]      in_imm,
    input  logic [2:0]       in_select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instruction,
    output logic [1:0]       out_err_code,
    output logic [CNT_W-1:0] err_count
);
    logic        s1_v;
    logic        s2_v;
    logic [31:0] s1_template;
    logic [31:0] s1_imm;
    logic [2:0]  s1_sel;
    logic        s2_adv;
    logic        ext11;
    logic        ext12;
    logic        ext20;
    logic [31:0] enc;
    logic [1:0]  err;

    assign s2_adv    = !s2_v || out_ready;
    assign in_ready  = !s1_v || s2_adv;
    assign out_valid = s2_v;

    // the immediate fits its field when every bit above the field's sign bit matches it
    assign ext11 = &s1_imm[31:11] || ~|s1_imm[31:11];
    assign ext12 = &s1_imm[31:12] || ~|s1_imm[31:12];
    assign ext20 = &s1_imm[31:20] || ~|s1_imm[31:20];

    always_comb begin
        enc = s1_template;
        err = 2'b00;
        case (s1_sel)
            3'd0: begin
                enc[31:12] = s1_imm[31:12];
                err        = |s1_imm[11:0] ? 2'b01 : 2'b00;
            end
            3'd1: begin
                enc[31:12] = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12]};
                err        = !ext20 ? 2'b01 : s1_imm[0] ? 2'b10 : 2'b00;
            end
            3'd2: begin
                enc[31:20] = s1_imm[11:0];
                err        = ext11 ? 2'b00 : 2'b01;
            end
            3'd3: begin
                enc[31:25] = {s1_imm[12], s1_imm[10:5]};
                enc[11:7]  = {s1_imm[4:1], s1_imm[11]};
                err        = !ext12 ? 2'b01 : s1_imm[0] ? 2'b10 : 2'b00;
            end
            3'd4: begin
                enc[31:25] = s1_imm[11:5];
                enc[11:7]  = s1_imm[4:0];
                err        = ext11 ? 2'b00 : 2'b01;
            end
            default: err = 2'b11;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v            <= 1'b0;
            s1_template     <= '0;
            s1_imm          <= '0;
            s1_sel          <= '0;
            s2_v            <= 1'b0;
            out_instruction <= '0;
            out_err_code    <= '0;
            err_count       <= '0;
        end else begin
            if (in_ready) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_template <= in_template;
                    s1_imm      <= in_imm;
                    s1_sel      <= in_select;
                end
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    out_instruction <= enc;
                    out_err_code    <= err;
                end
            end
            if (out_valid && out_ready && out_err_code != 2'b00 && !(&err_count))
                err_count <= err_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_immediate_encode.sv
// tb_immediate_encode: directed and randomized checks of immediate_encode against a field-table
// reference model with a scoreboard queue; counter width is reduced so saturation is reachable.
module tb_immediate_encode;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_template = '0;
    logic [31:0]      in_imm = '0;
    logic [2:0]       in_select = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_instruction;
    logic [1:0]       out_err_code;
    logic [CNT_W-1:0] err_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    immediate_encode #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_template(in_template), .in_imm(in_imm), .in_select(in_select),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_err_code(out_err_code),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // reference: per-bit field placement plus signed-range arithmetic
    function automatic void model(input logic [31:0] t, input logic [31:0] imm, input logic [2:0] sel,
                                  output logic [31:0] ins, output logic [1:0] e);
        int v;
        v   = $signed(imm);
        ins = t;
        e   = 2'b00;
        case (sel)
            3'd0: begin
                for (int k = 12; k < 32; k++) ins[k] = imm[k];
                e = (imm % 4096 != 0) ? 2'b01 : 2'b00;
            end
            3'd1: begin
                ins[31] = imm[20];
                for (int k = 1; k < 11; k++) ins[20+k] = imm[k];
                ins[20] = imm[11];
                for (int k = 12; k < 20; k++) ins[k] = imm[k];
                e = (v < -(1 << 20) || v >= (1 << 20)) ? 2'b01 : (v % 2 != 0) ? 2'b10 : 2'b00;
            end
            3'd2: begin
                for (int k = 0; k < 12; k++) ins[20+k] = imm[k];
                e = (v < -2048 || v > 2047) ? 2'b01 : 2'b00;
            end
            3'd3: begin
                ins[31] = imm[12];
                for (int k = 5; k < 11; k++) ins[20+k] = imm[k];
                for (int k = 1; k < 5; k++) ins[7+k] = imm[k];
                ins[7] = imm[11];
                e = (v < -4096 || v > 4095) ? 2'b01 : (v % 2 != 0) ? 2'b10 : 2'b00;
            end
            3'd4: begin
                for (int k = 5; k < 12; k++) ins[20+k] = imm[k];
                for (int k = 0; k < 5; k++) ins[7+k] = imm[k];
                e = (v < -2048 || v > 2047) ? 2'b01 : 2'b00;
            end
            default: e = 2'b11;
        endcase
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #3;
        n_vec++;
        if ({out_valid, out_instruction, out_err_code, err_count} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b ins=%h e=%b cnt=%0d, expected all zero",
                     out_valid, out_instruction, out_err_code, err_count);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] t[7]  = '{32'h00000013, 32'h00002023, 32'h00000063, 32'h00000037,
                               32'h00000013, 32'h0000006F, 32'hDEADBEEF};
        logic [31:0] im[7] = '{32'hFFFFFFFF, 32'h000007FC, 32'hFFFFFFFC, 32'h12345000,
                               32'h00000800, 32'h00000801, 32'h00000004};
        logic [2:0]  s[7]  = '{3'd2, 3'd4, 3'd3, 3'd0, 3'd2, 3'd1, 3'd6};
        logic [31:0] xi[7] = '{32'hFFF00013, 32'h7E002E23, 32'hFE000EE3, 32'h12345037,
                               32'h80000013, 32'h0010006F, 32'hDEADBEEF};
        logic [1:0]  xe[7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            in_valid = 1'b1; in_template = t[n]; in_imm = im[n]; in_select = s[n];
            #1;
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL dir_in_ready[%0d]: got %b expected 1", n, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL dir_early_valid[%0d]: got %b expected 0", n, out_valid);
            end
            @(negedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || out_instruction !== xi[n] || out_err_code !== xe[n]) begin
                n_err++;
                $display("FAIL dir_word[%0d]: got v=%b ins=%h e=%b expected v=1 ins=%h e=%b",
                         n, out_valid, out_instruction, out_err_code, xi[n], xe[n]);
            end
            if (xe[n] != 2'b00) exp_cnt++;
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (err_count !== CNT_W'(exp_cnt) || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL dir_err_count: got cnt=%0d v=%b expected cnt=%0d v=0", err_count, out_valid, exp_cnt);
        end
    endtask

    task automatic test_stream(input int n, input bit b2b);
        logic [31:0] q_ins[$];
        logic [1:0]  q_err[$];
        logic [31:0] t, im, r, mi, h_ins;
        logic [1:0]  me, h_err;
        logic [2:0]  s;
        bit          have = 0, stalled = 0;
        int          sent = 0, rcv = 0, cyc = 0;
        while (rcv < n && cyc < n * 20 + 50) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_instruction !== h_ins || out_err_code !== h_err) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b ins=%h e=%b expected v=1 ins=%h e=%b",
                             out_valid, out_instruction, out_err_code, h_ins, h_err);
                end
            end
            n_vec++;
            if (err_count !== CNT_W'(exp_cnt)) begin
                n_err++;
                $display("FAIL stream_err_count: got %0d expected %0d", err_count, exp_cnt);
            end
            if (!have) begin
                r  = $urandom;
                s  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
                case ($urandom_range(0, 3))
                    0: im = $urandom;
                    1: im = {{19{r[12]}}, r[12:0]};
                    2: im = {{11{r[20]}}, r[20:0]};
                    default: im = {r[31:12], 12'h000};
                endcase
                if ($urandom_range(0, 1) == 1) im[0] = 1'b0;
                t    = $urandom;
                have = 1;
            end
            out_ready   = 1'($urandom_range(0, 1));
            in_valid    = (sent < n) && (b2b || $urandom_range(0, 3) != 0);
            in_template = t; in_imm = im; in_select = s;
            #1;
            n_vec++;
            if (in_ready !== (q_ins.size() < 2 || out_ready)) begin
                n_err++;
                $display("FAIL stream_in_ready: got %b expected %b", in_ready, q_ins.size() < 2 || out_ready);
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (q_ins.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_spurious: got word %h expected none", out_instruction);
                end else begin
                    mi = q_ins.pop_front();
                    me = q_err.pop_front();
                    if (out_instruction !== mi || out_err_code !== me) begin
                        n_err++;
                        $display("FAIL stream_word[%0d]: got ins=%h e=%b expected ins=%h e=%b",
                                 rcv, out_instruction, out_err_code, mi, me);
                    end
                    if (me != 2'b00 && exp_cnt < MAXC) exp_cnt++;
                end
                rcv++;
            end
            stalled = out_valid && !out_ready;
            h_ins   = out_instruction;
            h_err   = out_err_code;
            if (in_valid && in_ready) begin
                model(t, im, s, mi, me);
                q_ins.push_back(mi);
                q_err.push_back(me);
                sent++;
                have = 0;
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (rcv != n) begin
            n_err++;
            $display("FAIL stream_timeout: got %0d words expected %0d", rcv, n);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            in_valid = 1'b1; in_template = 32'h00000013; in_imm = 32'($urandom); in_select = 3'd5;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        exp_cnt = MAXC;
        n_vec++;
        if (err_count !== CNT_W'(MAXC) || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL saturate: got cnt=%0d v=%b expected cnt=%0d v=0", err_count, out_valid, MAXC);
        end
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        logic [31:0] got = '0;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_template = 32'h00000013; in_imm = 32'h0; in_select = 3'd7;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_prefill: got v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || err_count !== '0 || out_instruction !== '0 || out_err_code !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got v=%b cnt=%0d ins=%h e=%b expected all zero",
                     out_valid, err_count, out_instruction, out_err_code);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        exp_cnt   = 0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_template = 32'h00000013; in_imm = 32'h00000005; in_select = 3'd2;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid) begin
                seen++;
                got = out_instruction;
            end
            @(negedge clk);
        end
        #1;
        n_vec++;
        if (seen != 1 || got !== 32'h00500013 || err_count !== '0) begin
            n_err++;
            $display("FAIL mid_after: got words=%0d ins=%h cnt=%0d expected words=1 ins=00500013 cnt=0",
                     seen, got, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream(6, 1'b1);
        test_stream(300, 1'b0);
        test_saturate();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
